// File: rtl/mac_accumulator.sv
// mac_accumulator: streams A/B pairs, accumulates K products, emits one saturated C element per dot product
module mac_accumulator #(
    parameter int NUM_BITS = 16,
    parameter int K        = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_BITS-1:0] a_i,
    input  logic [NUM_BITS-1:0] b_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                abort_i,
    output logic [NUM_BITS-1:0] c_o,
    output logic                c_valid_o,
    output logic                sat_o
);
    localparam int PW = 2 * NUM_BITS;
    localparam int AW = PW + $clog2(K);
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, EMIT} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [AW-1:0]       r_acc;
    logic [PW-1:0]       r_p;
    logic                r_pv;
    logic [NUM_BITS-1:0] r_c;
    logic                r_cv;
    logic                r_sat;

    logic                w_take;
    logic                w_last;
    logic                w_sat;
    logic [PW-1:0]       w_prod;

    assign in_ready_o = ~rst_i & (r_state != FLUSH);
    assign w_take     = in_valid_i & in_ready_o;
    assign w_last     = r_cnt == LAST;
    assign w_sat      = |r_acc[AW-1:NUM_BITS];
    assign w_prod     = a_i * b_i;
    assign c_o        = r_c;
    assign c_valid_o  = r_cv;
    assign sat_o      = r_sat;

    // Beat counting and result emission; abort never suppresses a pulse already in EMIT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_c     <= '0;
            r_cv    <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_cv <= r_state == EMIT;
            if (r_state == EMIT) begin
                r_c   <= w_sat ? '1 : r_acc[NUM_BITS-1:0];
                r_sat <= w_sat;
            end
            if (abort_i) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: if (w_take) begin
                        r_state <= ACCUM;
                        r_cnt   <= CW'(1);
                    end
                    ACCUM: if (w_take) begin
                        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                        r_state <= w_last ? FLUSH : ACCUM;
                    end
                    FLUSH: r_state <= EMIT;
                    EMIT: begin
                        r_state <= w_take ? ACCUM : IDLE;
                        r_cnt   <= w_take ? CW'(1) : '0;
                    end
                endcase
            end
        end
    end

    // Product register: one full-precision product per accepted beat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p  <= '0;
            r_pv <= 1'b0;
        end else begin
            r_pv <= w_take & ~abort_i;
            if (w_take)
                r_p <= w_prod;
        end
    end

    // Accumulator: cleared when a result is taken or the vector is aborted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_acc <= '0;
        else if (abort_i || r_state == EMIT)
            r_acc <= '0;
        else if (r_pv)
            r_acc <= r_acc + AW'(r_p);
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed and randomised-gap checks of the MAC accumulator
module tb_mac_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b, a2, b2, a7, b7;
    logic       iv, iv2, iv7, ab, ab2, ab7;
    logic       rdy, rdy2, rdy7, cv, cv2, cv7, sat, sat2, sat7;
    logic [7:0] c, c2, c7;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.NUM_BITS(8), .K(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .in_valid_i(iv), .in_ready_o(rdy),
        .abort_i(ab), .c_o(c), .c_valid_o(cv), .sat_o(sat));
    mac_accumulator #(.NUM_BITS(8), .K(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .a_i(a2), .b_i(b2), .in_valid_i(iv2), .in_ready_o(rdy2),
        .abort_i(ab2), .c_o(c2), .c_valid_o(cv2), .sat_o(sat2));
    mac_accumulator #(.NUM_BITS(8), .K(7)) u_dut7 (
        .clk_i(clk), .rst_i(rst), .a_i(a7), .b_i(b7), .in_valid_i(iv7), .in_ready_o(rdy7),
        .abort_i(ab7), .c_o(c7), .c_valid_o(cv7), .sat_o(sat7));

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] x, input logic [7:0] y);
        a = x; b = y; iv = 1'b1;
        cyc();
    endtask

    task automatic wait_strobe(input int max, output bit got);
        iv = 1'b0;
        got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            if (cv) got = 1'b1;
            else cyc();
        end
    endtask

    task automatic test_reset();
        cyc(); cyc();
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", rdy); end
        tests++; if (cv !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", cv); end
        tests++; if (c !== 8'd0) begin fails++; $display("FAIL reset_c: got %0d want 0", c); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", sat); end
        rst = 1'b0;
        cyc();
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", rdy); end
    endtask

    task automatic test_basic();
        beat(1, 2); beat(2, 2); beat(3, 2); beat(4, 2);
        iv = 1'b0;
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL basic_flush_ready: got %b want 0", rdy); end
        tests++; if (cv !== 1'b0) begin fails++; $display("FAIL basic_early_t1: got %b want 0", cv); end
        cyc();
        tests++; if (cv !== 1'b0 || rdy !== 1'b1) begin fails++; $display("FAIL basic_emit_cycle: got valid %b ready %b want 0 1", cv, rdy); end
        cyc();
        tests++; if (cv !== 1'b1) begin fails++; $display("FAIL basic_strobe: got %b want 1", cv); end
        tests++; if (c !== 8'd20) begin fails++; $display("FAIL basic_c: got %0d want 20", c); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL basic_sat: got %b want 0", sat); end
        cyc();
        tests++; if (cv !== 1'b0 || c !== 8'd20) begin fails++; $display("FAIL basic_hold: got valid %b c %0d want 0 20", cv, c); end
    endtask

    task automatic test_saturation();
        bit got;
        repeat (4) beat(255, 255);
        wait_strobe(6, got);
        tests++; if (!got) begin fails++; $display("FAIL sat_strobe: got none want 1"); end
        tests++; if (c !== 8'd255 || sat !== 1'b1) begin fails++; $display("FAIL sat_clamp: got c %0d sat %b want 255 1", c, sat); end
        cyc();
        repeat (4) beat(1, 1);
        wait_strobe(6, got);
        tests++; if (!got) begin fails++; $display("FAIL sat_next_strobe: got none want 1"); end
        tests++; if (c !== 8'd4 || sat !== 1'b0) begin fails++; $display("FAIL sat_next: got c %0d sat %b want 4 0", c, sat); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int av[8];
        int bv[8];
        int res[2];
        int i = 0, ns = 0, lows = 0;
        bit took;
        av = '{1, 2, 3, 4, 1, 2, 3, 4};
        bv = '{2, 2, 2, 2, 4, 4, 4, 4};
        res = '{-1, -1};
        for (int k = 0; k < 18; k++) begin
            if (cv) begin
                if (ns < 2) res[ns] = int'(c);
                ns++;
            end
            if (!rdy) lows++;
            if (i < 8) begin a = 8'(av[i]); b = 8'(bv[i]); iv = 1'b1; end
            else iv = 1'b0;
            took = iv && rdy;
            cyc();
            if (took) i++;
        end
        tests++; if (i != 8) begin fails++; $display("FAIL b2b_beats: got %0d want 8", i); end
        tests++; if (ns != 2) begin fails++; $display("FAIL b2b_strobes: got %0d want 2", ns); end
        tests++; if (res[0] != 20 || res[1] != 40) begin fails++; $display("FAIL b2b_values: got %0d %0d want 20 40", res[0], res[1]); end
        tests++; if (lows != 2) begin fails++; $display("FAIL b2b_bubbles: got %0d want 2", lows); end
    endtask

    task automatic test_abort();
        int ns = 0;
        int last = -1;
        bit got;
        repeat (3) beat(5, 5);
        iv = 1'b0; ab = 1'b1;
        cyc();
        ab = 1'b0;
        repeat (4) beat(1, 1);
        iv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (cv) begin ns++; last = int'(c); end
            cyc();
        end
        tests++; if (ns != 1 || last != 4) begin fails++; $display("FAIL abort_accum: got %0d strobes c %0d want 1 4", ns, last); end
        repeat (4) beat(9, 9);
        iv = 1'b0; ab = 1'b1;
        cyc();
        ab = 1'b0;
        ns = 0;
        for (int k = 0; k < 6; k++) begin
            if (cv) ns++;
            cyc();
        end
        tests++; if (ns != 0 || c !== 8'd4) begin fails++; $display("FAIL abort_flush: got %0d strobes c %0d want 0 4", ns, c); end
        repeat (4) beat(2, 3);
        iv = 1'b0;
        cyc();
        ab = 1'b1; a = 7; b = 7; iv = 1'b1;
        cyc();
        ab = 1'b0; iv = 1'b0;
        tests++; if (cv !== 1'b1 || c !== 8'd24 || sat !== 1'b0) begin fails++; $display("FAIL abort_emit: got valid %b c %0d sat %b want 1 24 0", cv, c, sat); end
        repeat (4) beat(1, 1);
        wait_strobe(6, got);
        tests++; if (!got || c !== 8'd4) begin fails++; $display("FAIL abort_emit_drop: got strobe %b c %0d want 1 4", got, c); end
        cyc();
    endtask

    task automatic test_async_reset();
        bit got;
        int ns = 0;
        int last = -1;
        beat(9, 9); beat(9, 9);
        iv = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if (c !== 8'd0 || cv !== 1'b0 || sat !== 1'b0 || rdy !== 1'b0) begin fails++; $display("FAIL rst_accum: got c %0d valid %b sat %b ready %b want 0 0 0 0", c, cv, sat, rdy); end
        cyc();
        rst = 1'b0;
        cyc();
        repeat (4) beat(200, 200);
        wait_strobe(6, got);
        tests++; if (!got || c !== 8'd255 || sat !== 1'b1) begin fails++; $display("FAIL rst_recover: got strobe %b c %0d sat %b want 1 255 1", got, c, sat); end
        cyc();
        repeat (4) beat(2, 2);
        iv = 1'b0;
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL rst_in_flush: got ready %b want 0", rdy); end
        #2 rst = 1'b1;
        #1;
        tests++; if (c !== 8'd0 || sat !== 1'b0 || rdy !== 1'b0) begin fails++; $display("FAIL rst_flush: got c %0d sat %b ready %b want 0 0 0", c, sat, rdy); end
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (cv) begin ns++; last = int'(c); end
            if (k < 4) begin a = 8'(k + 1); b = 2; iv = 1'b1; end
            else iv = 1'b0;
            cyc();
        end
        tests++; if (ns != 1 || last != 20) begin fails++; $display("FAIL rst_next_vector: got %0d strobes c %0d want 1 20", ns, last); end
    endtask

    task automatic test_random_gaps();
        int q2[$];
        int q7[$];
        int s2 = 0, s7 = 0, n2 = 0, n7 = 0, e;
        for (int k = 0; k < 330; k++) begin
            if (cv2) begin
                tests++;
                if (q2.size() == 0) begin fails++; $display("FAIL k2_extra: got c %0d want no strobe", c2); end
                else begin
                    e = q2.pop_front();
                    if ({sat2, c2} !== e[8:0]) begin fails++; $display("FAIL k2_value: got sat %b c %0d want sat %b c %0d", sat2, c2, e[8], e[7:0]); end
                end
            end
            if (cv7) begin
                tests++;
                if (q7.size() == 0) begin fails++; $display("FAIL k7_extra: got c %0d want no strobe", c7); end
                else begin
                    e = q7.pop_front();
                    if ({sat7, c7} !== e[8:0]) begin fails++; $display("FAIL k7_value: got sat %b c %0d want sat %b c %0d", sat7, c7, e[8], e[7:0]); end
                end
            end
            if (k < 300) begin
                iv2 = $urandom_range(0, 2) != 0;
                a2 = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
                b2 = 8'($urandom_range(0, 12));
                iv7 = $urandom_range(0, 2) != 0;
                a7 = 8'($urandom_range(0, 9));
                b7 = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            end else begin
                iv2 = 1'b0;
                iv7 = 1'b0;
            end
            if (iv2 && rdy2) begin
                s2 += int'(a2) * int'(b2);
                n2++;
                if (n2 == 2) begin q2.push_back(s2 > 255 ? 511 : s2); s2 = 0; n2 = 0; end
            end
            if (iv7 && rdy7) begin
                s7 += int'(a7) * int'(b7);
                n7++;
                if (n7 == 7) begin q7.push_back(s7 > 255 ? 511 : s7); s7 = 0; n7 = 0; end
            end
            cyc();
        end
        tests++; if (q2.size() != 0) begin fails++; $display("FAIL k2_missing: got %0d pending want 0", q2.size()); end
        tests++; if (q7.size() != 0) begin fails++; $display("FAIL k7_missing: got %0d pending want 0", q7.size()); end
    endtask

    initial begin
        rst = 1'b1;
        {a, b, a2, b2, a7, b7} = '0;
        {iv, iv2, iv7, ab, ab2, ab7} = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
